multdiv_unit: RTL
=================

Name: multdiv_unit

Overview:
- Iterative signed 32-bit multiply/divide unit.
- Acts as the responder to the processor's X-stage mult/div stall handshake.
- The processor pulses a start strobe with two operands. The unit computes for a fixed number of cycles, then pulses ready with the result and an exception flag.
- While `busy` is high, the processor's stall logic holds PC, FD and DX.

Parameters:
- WIDTH, 32, operand/result width; also the iteration count (latency) for both operations.

Ports:
- clock  input  1  master clock, rising-edge.
- reset  input  1  asynchronous, active-low (0 = reset).
- ctrl_MULT  input  1  one-cycle start pulse for multiply.
- ctrl_DIV  input  1  one-cycle start pulse for divide.
- data_operandA  input  WIDTH  multiplicand / dividend, two's complement.
- data_operandB  input  WIDTH  multiplier / divisor, two's complement.
- data_result  output  WIDTH  product (low WIDTH bits) or quotient.
- data_exception  output  1  overflow or divide-by-zero.
- data_resultRDY  output  1  one-cycle result-valid pulse.
- busy  output  1  operation in progress (RUN or DONE state).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; iteration counter=0.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - All internal operand, partial-product and remainder registers are cleared.
  - Release of reset is synchronous to the next clock edge.
- States: IDLE, MUL_RUN, DIV_RUN, DONE.
- Start:
  - At any rising edge where ctrl_MULT=1 or ctrl_DIV=1 (edge 0), operands are captured and the counter is cleared. Next state is MUL_RUN or DIV_RUN.
  - Both strobes high together: multiply takes priority.
  - Operands are not required to stay stable after edge 0.
- RUN:
  - One iteration per edge, edges 1..WIDTH.
  - Multiply: shift-add on magnitudes with the sign applied at the end. Alternatively signed Booth; either way the result must match the 2*WIDTH-bit product.
  - Divide: restoring or non-restoring on magnitudes. Quotient truncates toward zero; the remainder is discarded.
  - At edge WIDTH: result and exception registers load and state goes to DONE.
- DONE:
  - data_resultRDY=1 for exactly one cycle: high after edge WIDTH, low after edge WIDTH+1.
  - Next state is IDLE, unless a new start is sampled at that edge.
- busy: 1 from after edge 0 through the DONE cycle inclusive; 0 in IDLE.
- data_result and data_exception hold their last values through IDLE. They are overwritten only at a completion.
- New start while in RUN or DONE:
  - The current operation is aborted and no RDY pulse is issued for it.
  - New operands are captured and the counter restarts from 0.
- Reset mid-operation: immediate return to IDLE; no RDY pulse.
- Multiply exception:
  - data_exception=1 iff the full signed 2*WIDTH-bit product does not fit in WIDTH signed bits.
  - data_result is always the low WIDTH bits of the product.
- Divide exception:
  - Divisor=0 → data_result=0, data_exception=1, with the same latency (WIDTH).
  - INT_MIN / -1 → data_result=INT_MIN (0x80000000), data_exception=1.
  - Otherwise data_exception=0.
- Latency is fixed at WIDTH+1 edges from start to RDY sampled high by the consumer, independent of operand values.

Test Plan:
- Multiply, small signed: ctrl_MULT pulse, A=7, B=-3 → after edge 32: RDY=1 for one cycle, result=0xFFFFFFEB (-21), exc=0, busy drops after DONE.
- Multiply overflow: A=0x00010000, B=0x00010000 → result=0x00000000, exc=1. Separately, A=0x80000000, B=-1 → result=0x80000000, exc=1.
- Divide: A=-100, B=7 → result=-14 (0xFFFFFFF2), exc=0. Then A=100, B=-7 → result=-14, exc=0.
- Divide special cases: A=5, B=0 → result=0, exc=1 at edge 32. A=0x80000000, B=-1 → result=0x80000000, exc=1.
- Restart: ctrl_MULT with 3*4 at edge 0, then ctrl_DIV with 100/10 at edge 10 → exactly one RDY pulse, after edge 42, result=10, exc=0; no pulse near edge 32.
- Reset and hold: start 6*7, drive reset=0 asynchronously mid-cycle at ~edge 15 → all outputs 0 immediately, no RDY. Release reset and run 6*7 → result=42; result stays 42 in IDLE for 20+ cycles with RDY=0.

Source files
------------

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide responder for the X-stage stall handshake.
// Each operation takes WIDTH iterations on operand magnitudes; the sign is applied when the operation completes.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opnd_q;   // |B|: multiplicand or divisor
  logic [WIDTH-1:0] hi_q;     // product high half / partial remainder
  logic [WIDTH-1:0] lo_q;     // multiplier being shifted out / dividend becoming quotient
  logic             neg_q;
  logic             dz_q;

  logic             start;
  logic             last;

  logic             mul_carry;
  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
  logic [2*WIDTH-1:0] mul_mag, mul_prod;
  logic [WIDTH:0]   mul_top;
  logic             mul_exc;

  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem_n, div_quo_n, div_quo_s;
  logic [WIDTH-1:0] div_res;
  logic             div_exc;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    // The most negative value maps to 2**(WIDTH-1), which still fits as unsigned.
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  assign start = ctrl_MULT | ctrl_DIV;
  assign last  = (cnt == CW'(WIDTH - 1));

  // One shift-add step: add |B| when the outgoing multiplier bit is set, then shift right.
  always_comb begin
    {mul_carry, mul_sum} = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi_n = {mul_carry, mul_sum[WIDTH-1:1]};
    mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    mul_mag  = {mul_hi_n, mul_lo_n};
    mul_prod = neg_q ? (~mul_mag + 1'b1) : mul_mag;
    mul_top  = mul_prod[2*WIDTH-1:WIDTH-1];
    mul_exc  = !((&mul_top) | ~(|mul_top));
  end

  // One restoring-division step; the quotient bit enters where the dividend bit left.
  always_comb begin
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ok    = !div_diff[WIDTH];
    div_rem_n = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_quo_n = {lo_q[WIDTH-2:0], div_ok};
    div_quo_s = neg_q ? (~div_quo_n + 1'b1) : div_quo_n;
    // A positive quotient with the top bit set is only reachable as INT_MIN / -1.
    div_exc   = dz_q | (!neg_q & div_quo_n[WIDTH-1]);
    div_res   = dz_q ? '0 : div_quo_s;
  end

  // NOTE: next-state is assigned a default before any branch so no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ctrl_MULT ? MUL_RUN : DIV_RUN;
    end else begin
      unique case (state)
        MUL_RUN, DIV_RUN: if (last) state_nxt = DONE;
        DONE:             state_nxt = IDLE;
        default:          state_nxt = IDLE;
      endcase
    end
  end

  assign busy           = (state != IDLE);
  assign data_resultRDY = (state == DONE);

  // NOTE: every register here is plain flops (no memory array), so all are cleared by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      opnd_q         <= '0;
      hi_q           <= '0;
      lo_q           <= '0;
      neg_q          <= 1'b0;
      dz_q           <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
      if (start) begin
        cnt    <= '0;
        hi_q   <= '0;
        lo_q   <= mag(data_operandA);
        opnd_q <= mag(data_operandB);
        neg_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        dz_q   <= (data_operandB == '0);
      end else begin
        unique case (state)
          MUL_RUN: begin
            hi_q <= mul_hi_n;
            lo_q <= mul_lo_n;
            cnt  <= cnt + CW'(1);
            if (last) begin
              data_result    <= mul_prod[WIDTH-1:0];
              data_exception <= mul_exc;
            end
          end
          DIV_RUN: begin
            hi_q <= div_rem_n;
            lo_q <= div_quo_n;
            cnt  <= cnt + CW'(1);
            if (last) begin
              data_result    <= div_res;
              data_exception <= div_exc;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
